// File: rtl/latch_write_arbiter.sv
// latch_write_arbiter: round-robin writer arbitration for one shared level-sensitive latch.
// Timing: grant, then SETUP_CYC cycles with data only, EN_CYC cycles with enable high, HOLD_CYC cycles with data only.
// Define LATCH_ARB_FIXED_PRIORITY_EN to make the lowest-indexed requester win, with no round-robin pointer.
module latch_write_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int SETUP_CYC = 1,
    parameter int EN_CYC    = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                    clk_in,
    input  logic                    n_rst_in,
    input  logic [N_REQ-1:0]        req_in,
    input  logic [N_REQ*DATA_W-1:0] data_in,
    output logic [N_REQ-1:0]        grant_out,
    output logic [N_REQ-1:0]        done_out,
    output logic                    latch_en_out,
    output logic [DATA_W-1:0]       latch_d_out,
    output logic                    busy_out
);
    localparam int MAXC = (SETUP_CYC > EN_CYC) ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                                               : ((EN_CYC > HOLD_CYC) ? EN_CYC : HOLD_CYC);
    localparam int CW = $clog2(MAXC + 1);
    localparam int IW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, SETUP, ENABLE, HOLD} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [IW-1:0]   pick;
    logic            last;

    assign last     = (cnt == '0);
    assign busy_out = (state != IDLE);

`ifdef LATCH_ARB_FIXED_PRIORITY_EN
    // lowest-indexed active request wins
    always_comb begin
        pick = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (req_in[IW'(i)]) pick = IW'(i);
    end
`else
    logic [IW-1:0] ptr, win, idx;

    // first active request at or after the pointer, wrapping; the downward scan leaves the nearest one
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = IW'((int'(ptr) + i) % N_REQ);
            if (req_in[idx]) pick = idx;
        end
    end
`endif

    // phase sequencing; the shared down-counter is reloaded on each phase entry
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE:    if (|req_in) begin state_n = SETUP; cnt_n = CW'(SETUP_CYC - 1); end
            SETUP:   if (last) begin state_n = ENABLE; cnt_n = CW'(EN_CYC - 1); end else cnt_n = cnt - 1'b1;
            ENABLE:  if (last) begin state_n = HOLD; cnt_n = CW'(HOLD_CYC - 1); end else cnt_n = cnt - 1'b1;
            HOLD:    if (last) state_n = IDLE; else cnt_n = cnt - 1'b1;
            default: state_n = IDLE;
        endcase
    end

    // registered outputs follow the next state so enable and done line up exactly with their phases
    always_ff @(posedge clk_in or negedge n_rst_in) begin
        if (!n_rst_in) begin
            state        <= IDLE;
            cnt          <= '0;
            grant_out    <= '0;
            done_out     <= '0;
            latch_en_out <= 1'b0;
            latch_d_out  <= '0;
`ifndef LATCH_ARB_FIXED_PRIORITY_EN
            ptr          <= '0;
            win          <= '0;
`endif
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            latch_en_out <= (state_n == ENABLE);
            done_out     <= (state_n == HOLD && cnt_n == '0) ? grant_out : '0;
            if (state == IDLE && |req_in) begin
                grant_out   <= N_REQ'(1) << pick;
                latch_d_out <= data_in[pick*DATA_W +: DATA_W];
`ifndef LATCH_ARB_FIXED_PRIORITY_EN
                win         <= pick;
`endif
            end else if (state == HOLD && last) begin
                grant_out <= '0;
`ifndef LATCH_ARB_FIXED_PRIORITY_EN
                ptr       <= (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
`endif
            end
        end
    end
endmodule

// File: tb/tb_latch_write_arbiter.sv
// tb_latch_write_arbiter: directed vectors for latch_write_arbiter with default parameters.
module tb_latch_write_arbiter;
    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] data = '0;
    logic [3:0]  grant, done;
    logic        en, busy;
    logic [7:0]  d;
    int          checks = 0;
    int          failures = 0;

    latch_write_arbiter dut (
        .clk_in(clk), .n_rst_in(n_rst), .req_in(req), .data_in(data),
        .grant_out(grant), .done_out(done), .latch_en_out(en),
        .latch_d_out(d), .busy_out(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] e;
        repeat (2) tick();
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_en", en, 0);
        chk("rst_d", d, 0);
        chk("rst_busy", busy, 0);
        n_rst = 1'b1;
        tick();
`ifdef LATCH_ARB_FIXED_PRIORITY_EN
        req = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("fp_grant", grant, 4'b0001);
            repeat (3) tick();
            chk("fp_done", done, 4'b0001);
            tick();
            chk("fp_gap", grant, 4'b0000);
        end
        req = '0;
        tick();
`else
        // single request, defaults
        req = 4'b0100;
        data = 32'h11A5_2233;
        tick();
        chk("s_grant", grant, 4'b0100);
        chk("s_d", d, 8'hA5);
        chk("s_en0", en, 0);
        chk("s_busy", busy, 1);
        req = '0;
        tick();
        chk("s_en1", en, 1);
        tick();
        chk("s_en2", en, 1);
        chk("s_done2", done, 0);
        tick();
        chk("s_en3", en, 0);
        chk("s_done3", done, 4'b0100);
        chk("s_grant3", grant, 4'b0100);
        tick();
        chk("s_busy4", busy, 0);
        chk("s_grant4", grant, 0);
        chk("s_done4", done, 0);
        // wrap-around: pointer is now 3
        req = 4'b1001;
        tick();
        chk("w_grant3", grant, 4'b1000);
        repeat (3) tick();
        chk("w_done3", done, 4'b1000);
        tick();
        chk("w_gap", grant, 0);
        tick();
        chk("w_grant0", grant, 4'b0001);
        req = '0;
        repeat (4) tick();
        chk("w_idle", busy, 0);
        // reset pointer, then all requesting continuously
        n_rst = 1'b0;
        #2 n_rst = 1'b1;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            e = 4'b0001 << (k % 4);
            tick();
            chk("rr_grant", grant, e);
            repeat (3) tick();
            chk("rr_done", done, e);
            tick();
            chk("rr_gap", grant, 0);
        end
        req = '0;
        tick();
        // data and request changed mid-transaction
        req = 4'b0010;
        data = 32'h0000_3C00;
        tick();
        chk("m_grant", grant, 4'b0010);
        chk("m_d0", d, 8'h3C);
        data = 32'h0000_FF00;
        req = '0;
        tick();
        chk("m_d1", d, 8'h3C);
        chk("m_en1", en, 1);
        tick();
        chk("m_en2", en, 1);
        tick();
        chk("m_done", done, 4'b0010);
        chk("m_d3", d, 8'h3C);
        tick();
        chk("m_idle", busy, 0);
        // asynchronous reset during ENABLE
        req = 4'b0100;
        tick();
        chk("r_grant", grant, 4'b0100);
        req = '0;
        tick();
        chk("r_en", en, 1);
        #2 n_rst = 1'b0;
        #1;
        chk("r_en_async", en, 0);
        chk("r_grant_async", grant, 0);
        chk("r_busy_async", busy, 0);
        #2 n_rst = 1'b1;
        repeat (3) begin
            tick();
            chk("r_no_done", done, 0);
        end
        req = 4'b0011;
        tick();
        chk("r_ptr0", grant, 4'b0001);
        req = '0;
        repeat (4) tick();
        chk("r_idle", busy, 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/latch_write_arbiter.md
Name: latch_write_arbiter

Overview:
- Shares one level-sensitive latch (enable, data, active-low reset) among N_REQ requesters.
- Arbitrates requests round-robin and captures the winner's data.
- Sequences the latch enable with guaranteed data setup and hold margins, measured in clock cycles.
- Sits between requester logic and the latch. It is the only block that drives the latch's enable and data inputs.

Parameters:
- N_REQ, 4, number of requesters (>=2)
- DATA_W, 8, latch data width
- SETUP_CYC, 1, cycles data is stable before enable rises (>=1)
- EN_CYC, 2, cycles enable is held high (>=1)
- HOLD_CYC, 1, cycles data is held after enable falls (>=1)

Ports:
- clk_in  input  1  system clock, rising edge
- n_rst_in  input  1  asynchronous active-low reset
- req_in  input  N_REQ  per-requester write request, level
- data_in  input  N_REQ*DATA_W  per-requester write data; requester i uses bits [i*DATA_W +: DATA_W]
- grant_out  output  N_REQ  one-hot grant, held for the whole transaction
- done_out  output  N_REQ  one-cycle completion pulse to the granted requester
- latch_en_out  output  1  enable to the shared latch, registered
- latch_d_out  output  DATA_W  data to the shared latch, registered
- busy_out  output  1  high whenever state is not IDLE

Behaviour:
- Reset (asynchronous, n_rst_in low):
  - state=IDLE; grant_out, done_out, latch_en_out, latch_d_out and busy_out all 0.
  - Round-robin pointer=0.
  - Reset mid-transaction drops latch_en_out immediately; the transaction is abandoned and no done_out is issued.
- FSM states: IDLE, SETUP, ENABLE, HOLD. A single down-counter sized for max(SETUP_CYC, EN_CYC, HOLD_CYC) times each state.
- IDLE:
  - If any req_in bit is set at a clock edge, pick the winner: the first set bit at or after the pointer, wrapping modulo N_REQ.
  - On that edge: grant_out=one-hot(winner), latch_d_out=winner's data_in slice, state moves to SETUP.
- SETUP: lasts SETUP_CYC cycles with latch_en_out=0, then moves to ENABLE.
- ENABLE: latch_en_out=1 for exactly EN_CYC cycles, then moves to HOLD.
- HOLD:
  - latch_en_out=0 for HOLD_CYC cycles.
  - done_out[winner]=1 during the final HOLD cycle only.
  - Next edge: state=IDLE; grant_out=0; pointer=(winner+1) mod N_REQ.
- Data and grant stability:
  - latch_d_out is captured once at grant and stays constant through SETUP/ENABLE/HOLD.
  - Requester data_in changes after the grant are ignored.
- Request rules:
  - A requester deasserting req_in mid-transaction does not abort it; done_out still pulses.
  - Requests arriving while busy wait; no queueing beyond the req_in level.
- Timing and fairness:
  - Minimum spacing between successive grants: 1+SETUP_CYC+EN_CYC+HOLD_CYC cycles (one IDLE cycle is mandatory).
  - With defaults: grant at edge 0, latch_en_out high after edges 1–2, done_out after edge 3, IDLE after edge 4.
  - Starvation-free: a continuously requesting requester is granted within N_REQ transactions.
- Invariants:
  - grant_out is one-hot or zero.
  - latch_en_out is never high outside ENABLE.
  - done_out is never high outside HOLD.

Optional Feature:
- Macro: LATCH_ARB_FIXED_PRIORITY_EN.
- Defined: the winner is the lowest-indexed set req_in bit; the pointer is not implemented and does not update. Requester 0 may starve the others.
- Undefined: round-robin arbitration exactly as in Behaviour.
- Timing, FSM and every other behaviour are identical in both modes.

Test Plan:
- Single request, defaults: req_in=4'b0100, data_in[23:16]=8'hA5 at edge 0 →
  - grant_out=4'b0100 and latch_d_out=8'hA5 after edge 0.
  - latch_en_out=1 after edges 1 and 2 only.
  - done_out=4'b0100 after edge 3; busy_out=0 after edge 4.
- All request continuously, round-robin: req_in=4'b1111 held → grant order 0,1,2,3,0, with consecutive grants exactly 5 cycles apart.
- Data and request changed mid-transaction:
  - Requester 1 granted with 8'h3C, then data_in changes to 8'hFF and req_in[1] drops during SETUP.
  - latch_d_out stays 8'h3C, latch_en_out still pulses, done_out[1] still pulses.
- Async reset during ENABLE: n_rst_in low between edges → latch_en_out, grant_out and busy_out go 0 without waiting for a clock. After release, req_in=4'b0011 grants requester 0 (pointer reset).
- Wrap-around: after a grant to requester 3 with req_in=4'b1001 → the next grant goes to requester 0.
- LATCH_ARB_FIXED_PRIORITY_EN defined, req_in=4'b0011 held → requester 0 granted every transaction and requester 1 never.
